ahb_multi_arbiter: RTL

- Parametrised successor to the two-master/two-slave bus control FSM.
- Arbitrates NUM_MASTERS requesters onto one shared bus to NUM_SLAVES slaves, using rotating (round-robin) priority.
- Drives grant, master/slave mux selects and address/data phase enables; handles OKAY/ERROR/RETRY/SPLIT responses, including split masking and a bounded retry count.
- Sits between the master request logic and the address/data muxes of the bus fabric.

---
 rtl/ahb_multi_arbiter_if.sv | 44 ++++
 rtl/ahb_multi_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_multi_arbiter_if.sv
// ahb_multi_arbiter_if -- bundle between the bus arbiter and the fabric.
//
// Purpose: groups the request/response inputs and the grant/select/phase
// outputs of ahb_multi_arbiter into one interface.
//   master modport : arbiter side (drives grant, selects, phase enables, pulses)
//   slave  modport : fabric/requester side (drives requests and slave response)
// Signals:
//   busreq, m_write, split_release [NUM_MASTERS]   per-master inputs
//   m_slv [NUM_MASTERS*SW]                          per-master slave index, master 0 at LSBs
//   rdyout, respout[1:0]                            slave ready / response
//   grant [NUM_MASTERS], mst_sel [MW], slv_sel [NUM_SLAVES]
//   addr_en, wdata_en, rdata_en, error, timeout
interface ahb_multi_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int NUM_SLAVES  = 4
);
   localparam int MW = $clog2(NUM_MASTERS);
   localparam int SW = $clog2(NUM_SLAVES);

   logic [NUM_MASTERS-1:0]    busreq;
   logic [NUM_MASTERS-1:0]    m_write;
   logic [NUM_MASTERS*SW-1:0] m_slv;
   logic                      rdyout;
   logic [1:0]                respout;
   logic [NUM_MASTERS-1:0]    split_release;
   logic [NUM_MASTERS-1:0]    grant;
   logic [MW-1:0]             mst_sel;
   logic [NUM_SLAVES-1:0]     slv_sel;
   logic                      addr_en;
   logic                      wdata_en;
   logic                      rdata_en;
   logic                      error;
   logic                      timeout;

   modport master (
      input  busreq, m_write, m_slv, rdyout, respout, split_release,
      output grant, mst_sel, slv_sel, addr_en, wdata_en, rdata_en, error, timeout
   );

   modport slave (
      output busreq, m_write, m_slv, rdyout, respout, split_release,
      input  grant, mst_sel, slv_sel, addr_en, wdata_en, rdata_en, error, timeout
   );
endinterface

// File: rtl/ahb_multi_arbiter.sv
// ahb_multi_arbiter -- round-robin arbiter and bus control FSM for
// NUM_MASTERS requesters sharing one bus to NUM_SLAVES slaves.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ahb_multi_arbiter_if.master (requests, slave response, grant,
//          master/slave selects, address/data phase enables, error/timeout)
// Behaviour: IDLE picks the first eligible (requesting, not split-masked)
// master at or above the rotating pointer, then runs one ADDR cycle and a
// DATA phase until OKAY+ready, ERROR, SPLIT, or the retry limit ends it.
// All outputs are registered: they are computed from the next state.
// Optional feature macro: BUS_TIMEOUT_EN (wait-state timeout of TIMEOUT_CYC).
module ahb_multi_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int NUM_SLAVES  = 4,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 16
) (
   input logic                clk,
   input logic                rst,
   ahb_multi_arbiter_if.master bus
);
   localparam int MW = $clog2(NUM_MASTERS);
   localparam int SW = $clog2(NUM_SLAVES);
   localparam int RW = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                 state_q, state_d;
   logic [MW-1:0]          g_q, g_d, rr_q, rr_d, g_inc;
   logic                   wr_q, wr_d;
   logic [SW-1:0]          slv_q, slv_d;
   logic [RW-1:0]          retry_cnt_q, retry_cnt_d;
   logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d, set_mask, eligible;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, gnt_dec;
   logic [MW-1:0]          mst_sel_q, mst_sel_d;
   logic [NUM_SLAVES-1:0]  slv_sel_q, slv_sel_d, slv_dec;
   logic                   addr_en_q, addr_en_d, wdata_en_q, wdata_en_d;
   logic                   rdata_en_q, rdata_en_d, error_q, error_d;
   logic                   found;
   logic [MW-1:0]          pick;
   logic [SW-1:0]          m_slv_arr [NUM_MASTERS];
`ifdef BUS_TIMEOUT_EN
   localparam int WCW = $clog2(TIMEOUT_CYC + 1);
   logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                   timeout_q, timeout_d;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mst
         assign m_slv_arr[gi] = bus.m_slv[gi*SW +: SW];
         assign gnt_dec[gi]   = (g_d == MW'(gi));
      end
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
         // An out-of-range index matches no bit, so a decode error selects nothing.
         assign slv_dec[gi] = (slv_d == SW'(gi));
      end
   endgenerate

   assign eligible = bus.busreq & ~split_mask_q;
   assign g_inc    = (g_q == MW'(NUM_MASTERS - 1)) ? '0 : g_q + 1'b1;

   // Next-state / control process.
   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      wr_d        = wr_q;
      slv_d       = slv_q;
      rr_d        = rr_q;
      retry_cnt_d = retry_cnt_q;
      set_mask    = '0;
      error_d     = 1'b0;
      found       = 1'b0;
      pick        = '0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = 1'b0;
`endif
      // Rotating priority: scan from rr upward, wrapping.
      for (int i = 0; i < NUM_MASTERS; i++) begin
         logic [MW-1:0] idx;
         idx = MW'((32'(rr_q) + i) % NUM_MASTERS);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               g_d         = pick;
               wr_d        = bus.m_write[pick];
               slv_d       = m_slv_arr[pick];
               retry_cnt_d = '0;
               state_d     = ADDR;
            end
         end
         ADDR: begin
            if (32'(slv_q) >= NUM_SLAVES) begin
               error_d = 1'b1;
               rr_d    = g_inc;
               state_d = IDLE;
            end else begin
               state_d = DATA;
`ifdef BUS_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         DATA: begin
            case (bus.respout)
               2'b00: begin
                  if (bus.rdyout) begin
                     rr_d    = g_inc;
                     state_d = IDLE;
                  end
`ifdef BUS_TIMEOUT_EN
                  else if (wait_cnt_q == WCW'(TIMEOUT_CYC - 1)) begin
                     timeout_d = 1'b1;
                     rr_d      = g_inc;
                     state_d   = IDLE;
                  end else begin
                     wait_cnt_d = wait_cnt_q + 1'b1;
                  end
`endif
               end
               2'b01: begin
                  error_d = 1'b1;
                  rr_d    = g_inc;
                  state_d = IDLE;
               end
               2'b10: begin
                  if (retry_cnt_q == RW'(MAX_RETRY - 1)) begin
                     error_d = 1'b1;
                     rr_d    = g_inc;
                     state_d = IDLE;
                  end else begin
                     retry_cnt_d = retry_cnt_q + 1'b1;
                     state_d     = ADDR;
                  end
               end
               default: begin
                  set_mask = gnt_dec;
                  rr_d     = g_inc;
                  state_d  = IDLE;
               end
            endcase
         end
         default: state_d = IDLE;
      endcase
      // Set after clear: a SPLIT in the same cycle as a release wins.
      split_mask_d = (split_mask_q & ~bus.split_release) | set_mask;
   end

   // Registered outputs follow the state being entered.
   always_comb begin
      grant_d    = '0;
      mst_sel_d  = '0;
      slv_sel_d  = '0;
      addr_en_d  = 1'b0;
      wdata_en_d = 1'b0;
      rdata_en_d = 1'b0;
      if (state_d != IDLE) begin
         grant_d   = gnt_dec;
         mst_sel_d = g_d;
         slv_sel_d = slv_dec;
      end
      if (state_d == ADDR) addr_en_d = 1'b1;
      if (state_d == DATA) begin
         wdata_en_d = wr_d;
         rdata_en_d = ~wr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         g_q          <= '0;
         wr_q         <= 1'b0;
         slv_q        <= '0;
         rr_q         <= '0;
         retry_cnt_q  <= '0;
         split_mask_q <= '0;
         grant_q      <= '0;
         mst_sel_q    <= '0;
         slv_sel_q    <= '0;
         addr_en_q    <= 1'b0;
         wdata_en_q   <= 1'b0;
         rdata_en_q   <= 1'b0;
         error_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         wait_cnt_q   <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         wr_q         <= wr_d;
         slv_q        <= slv_d;
         rr_q         <= rr_d;
         retry_cnt_q  <= retry_cnt_d;
         split_mask_q <= split_mask_d;
         grant_q      <= grant_d;
         mst_sel_q    <= mst_sel_d;
         slv_sel_q    <= slv_sel_d;
         addr_en_q    <= addr_en_d;
         wdata_en_q   <= wdata_en_d;
         rdata_en_q   <= rdata_en_d;
         error_q      <= error_d;
`ifdef BUS_TIMEOUT_EN
         wait_cnt_q   <= wait_cnt_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign bus.grant    = grant_q;
   assign bus.mst_sel  = mst_sel_q;
   assign bus.slv_sel  = slv_sel_q;
   assign bus.addr_en  = addr_en_q;
   assign bus.wdata_en = wdata_en_q;
   assign bus.rdata_en = rdata_en_q;
   assign bus.error    = error_q;
`ifdef BUS_TIMEOUT_EN
   assign bus.timeout  = timeout_q;
`else
   assign bus.timeout  = 1'b0;
`endif
endmodule
